// File: rtl/adc_pkg.sv
// Shared encodings for the ADC capture sequencer: FSM state codes and default trigger level.
package adc_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_READOUT = 2'd3;

    localparam logic [7:0] TRIG_LEVEL_DEF = 8'd128;

    // Unsigned rising crossing of lvl between two consecutive samples.
    function automatic logic rising_cross(input logic [7:0] prev_smp,
                                          input logic [7:0] cur_smp,
                                          input logic [7:0] lvl);
        return (prev_smp < lvl) && (cur_smp >= lvl);
    endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Byte readout stream from the capture sequencer to its consumer (normally the UART transmitter).
interface adc_capture_ctrl_if;

    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;

    modport master (
        output OUT_DATA,
        output OUT_VALID,
        input  OUT_READY
    );

    modport slave (
        input  OUT_DATA,
        input  OUT_VALID,
        output OUT_READY
    );

endinterface

// File: rtl/adc_sample_ram.sv
// Simple dual-port sample buffer, one write port and one registered read port.
// Latency: read data appears 1 cycle after the read address; reads see pre-write contents.
// Backpressure: none; both ports accept an operation every cycle.
module adc_sample_ram #(
    parameter int AW = 10
) (
    input  logic          CLK,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_dat
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Single-shot ADC capture: free-running sample clock, arm/trigger FSM, burst into RAM, byte readout.
// Latency: trigger sample written on its own strobe; first byte valid 2 cycles after READOUT entry.
// Backpressure: OUT_READY low holds the current byte; capture itself never stalls.
module adc_capture_ctrl
    import adc_pkg::*;
#(
    parameter int         DIV        = 2,
    parameter int         DEPTH_LOG2 = 10,
    parameter logic [7:0] TRIG_LEVEL = TRIG_LEVEL_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ARM,
    input  logic               FORCE,
    input  logic [7:0]         ADC_D,
    output logic               ADC_CLK,
    adc_capture_ctrl_if.master out_bus,
    output logic               BUSY,
    output logic               DONE,
    output logic [1:0]         STATE
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

    logic [DIV_W-1:0]      div_cnt;
    logic                  adc_clk_q;
    logic                  div_wrap;
    logic                  sample_stb;

    logic [1:0]            state;
    logic [7:0]            cur;
    logic                  cur_vld;
    logic                  level_trig;

    logic [DEPTH_LOG2-1:0] wr_addr;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DEPTH_LOG2-1:0] ram_raddr;
    logic [7:0]            ram_q;
    logic                  q_vld;
    logic [7:0]            out_data;
    logic                  out_valid;
    logic                  hs;
    logic                  done_q;

    assign div_wrap   = (div_cnt == DIV_W'(DIV - 1));
    assign sample_stb = div_wrap && adc_clk_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt   <= '0;
            adc_clk_q <= 1'b0;
        end else if (div_wrap) begin
            div_cnt   <= '0;
            adc_clk_q <= ~adc_clk_q;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

    // cur still holds the previous sample on the strobe cycle, so it is the "prev" of the compare
    // while ADC_D is the sample being registered right now.
    assign level_trig = (state == ST_ARMED) && sample_stb && cur_vld
                        && rising_cross(cur, ADC_D, TRIG_LEVEL);

    assign wr_en = level_trig || ((state == ST_CAPTURE) && sample_stb);
    assign hs    = out_valid && out_bus.OUT_READY;

    // Fetch the next byte in the handshake cycle so OUT_VALID is low for only one cycle.
    assign ram_raddr = hs ? rd_addr + 1'b1 : rd_addr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            cur       <= '0;
            cur_vld   <= 1'b0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            q_vld     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (sample_stb) begin
                cur <= ADC_D;
            end

            case (state)
                ST_IDLE: begin
                    cur_vld <= 1'b0;
                    if (ARM) begin
                        state <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (sample_stb) begin
                        cur_vld <= 1'b1;
                    end
                    if (level_trig) begin
                        wr_addr <= wr_addr + 1'b1;
                        state   <= ST_CAPTURE;
                    end else if (FORCE) begin
                        state   <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    if (sample_stb) begin
                        wr_addr <= wr_addr + 1'b1;
                        if (wr_addr == LAST_ADDR) begin
                            state <= ST_READOUT;
                        end
                    end
                end

                ST_READOUT: begin
                    q_vld <= (!out_valid && !q_vld) || (hs && (rd_addr != LAST_ADDR));
                    if (q_vld) begin
                        out_data  <= ram_q;
                        out_valid <= 1'b1;
                    end
                    if (hs) begin
                        out_valid <= 1'b0;
                        rd_addr   <= rd_addr + 1'b1;
                        if (rd_addr == LAST_ADDR) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    adc_sample_ram #(
        .AW(DEPTH_LOG2)
    ) u_ram (
        .CLK    (CLK),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_dat (ADC_D),
        .rd_addr(ram_raddr),
        .rd_dat (ram_q)
    );

    assign ADC_CLK           = adc_clk_q;
    assign out_bus.OUT_DATA  = out_data;
    assign out_bus.OUT_VALID = out_valid;
    assign BUSY              = (state != ST_IDLE);
    assign DONE              = done_q;
    assign STATE             = state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl with DIV=2, DEPTH_LOG2=4: random ADC data checked against a
// sample-history model that picks the burst by the trigger rule.
module tb_adc_capture_ctrl;
    import adc_pkg::*;

    localparam int         DIV   = 2;
    localparam int         DL    = 4;
    localparam int         DEPTH = 16;
    localparam logic [7:0] TRIG  = 8'd128;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       ARM   = 1'b0;
    logic       FORCE = 1'b0;
    logic [7:0] ADC_D = 8'd0;
    logic       ADC_CLK;
    logic       BUSY;
    logic       DONE;
    logic [1:0] STATE;

    adc_capture_ctrl_if bus ();

    adc_capture_ctrl #(
        .DIV       (DIV),
        .DEPTH_LOG2(DL),
        .TRIG_LEVEL(TRIG)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .ARM    (ARM),
        .FORCE  (FORCE),
        .ADC_D  (ADC_D),
        .ADC_CLK(ADC_CLK),
        .out_bus(bus.master),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .STATE  (STATE)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Stimulus table and history of every value the DUT sampled on an ADC_CLK fall.
    logic [7:0] stim [64];
    int         stim_len   = 0;
    int         stim_start = 0;
    int         strobe_cnt = 0;
    logic [7:0] hist [$];
    int         arm_base   = 0;

    // Readout observations gathered by collect().
    logic [7:0] got_q [$];
    int         hs_cyc [$];
    int         done_cnt;
    int         viol_cnt;
    int         first_rd;
    int         first_vld;
    logic [1:0] done_state;

    initial begin
        int idx;
        forever begin
            @(negedge ADC_CLK);
            hist.push_back(ADC_D);
            strobe_cnt++;
            idx = strobe_cnt - stim_start;
            if (stim_len > 0) begin
                ADC_D = stim[(idx < stim_len) ? idx : stim_len - 1];
            end
        end
    end

    function automatic int find_trig(input int from);
        for (int i = from + 1; i < hist.size(); i++) begin
            if (hist[i-1] < TRIG && hist[i] >= TRIG) return i;
        end
        return -1;
    endfunction

    task automatic wait_strobe();
        int s;
        s = strobe_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (strobe_cnt != s) return;
        end
        tests++;
        fails++;
        $display("FAIL strobe_timeout: no ADC_CLK fall within 20 cycles, required one every %0d", 2 * DIV);
    endtask

    // Next strobe loads stim[0]; ARM (optionally with FORCE) follows so stim[0] is the first armed sample.
    task automatic start_armed(input bit with_force);
        stim_start = strobe_cnt + 1;
        wait_strobe();
        ARM      = 1'b1;
        FORCE    = with_force;
        arm_base = hist.size();
        @(negedge CLK);
        ARM   = 1'b0;
        FORCE = 1'b0;
    endtask

    // Gathers accepted bytes until DONE plus 3 cycles. ready_mode: 0 always, 1 random, 2 stall 10.
    task automatic collect(input int ready_mode, input bit force_pulse, input int budget);
        int         cyc;
        int         after;
        bit         seen_done;
        bit         prev_stall;
        logic [7:0] prev_data;
        int         stall_left;
        bit         forced;
        bit         rdy;
        got_q.delete();
        hs_cyc.delete();
        done_cnt = 0; viol_cnt = 0; first_rd = -1; first_vld = -1; done_state = 2'd3;
        cyc = 0; after = 0; seen_done = 0; prev_stall = 0; prev_data = 8'd0; stall_left = 10; forced = 0;
        while (1) begin
            @(negedge CLK);
            cyc++;
            if (STATE == ST_READOUT && first_rd < 0) first_rd = cyc;
            if (bus.OUT_VALID && first_vld < 0) first_vld = cyc;
            if (prev_stall && (!bus.OUT_VALID || bus.OUT_DATA !== prev_data)) viol_cnt++;
            if (DONE) begin
                done_cnt++;
                if (!seen_done) done_state = STATE;
                seen_done = 1;
            end
            FORCE = 1'b0;
            if (force_pulse && !forced && got_q.size() == 2) begin
                FORCE  = 1'b1;
                forced = 1;
            end
            rdy = 1'b1;
            if (ready_mode == 1) rdy = 1'($urandom_range(0, 1));
            if (ready_mode == 2 && got_q.size() == 3 && stall_left > 0) begin
                if (bus.OUT_VALID) stall_left--;
                rdy = 1'b0;
            end
            bus.OUT_READY = rdy;
            if (bus.OUT_VALID && rdy) begin
                got_q.push_back(bus.OUT_DATA);
                hs_cyc.push_back(cyc);
            end
            prev_stall = bus.OUT_VALID && !rdy;
            prev_data  = bus.OUT_DATA;
            if (seen_done) begin
                after++;
                if (after > 3) break;
            end
            if (cyc > budget) begin
                tests++;
                fails++;
                $display("FAIL collect_timeout: %0d bytes after %0d cycles, required DONE", got_q.size(), cyc);
                break;
            end
        end
        bus.OUT_READY = 1'b0;
        FORCE         = 1'b0;
    endtask

    task automatic test_reset();
        int  bad;
        int  bad_per;
        int  n_rise;
        int  first_rise;
        int  last_rise;
        bit  prev_adc;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        tests++; if (ADC_CLK !== 1'b0)       begin fails++; $display("FAIL rst_adc_clk: got %b required 0", ADC_CLK); end
        tests++; if (bus.OUT_DATA !== 8'd0)  begin fails++; $display("FAIL rst_out_data: got %0d required 0", bus.OUT_DATA); end
        tests++; if (bus.OUT_VALID !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b required 0", bus.OUT_VALID); end
        tests++; if (BUSY !== 1'b0)          begin fails++; $display("FAIL rst_busy: got %b required 0", BUSY); end
        tests++; if (DONE !== 1'b0)          begin fails++; $display("FAIL rst_done: got %b required 0", DONE); end
        tests++; if (STATE !== ST_IDLE)      begin fails++; $display("FAIL rst_state: got %0d required 0", STATE); end
        RST = 1'b0;
        bad = 0; bad_per = 0; n_rise = 0; first_rise = -1; last_rise = 0; prev_adc = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (BUSY !== 1'b0 || STATE !== ST_IDLE || bus.OUT_VALID !== 1'b0) bad++;
            if (ADC_CLK === 1'b1 && !prev_adc) begin
                if (first_rise < 0) first_rise = c;
                else if (c - last_rise != 2 * 2 * DIV / 2 * 2 / 2) bad_per++;
                last_rise = c;
                n_rise++;
            end
            prev_adc = (ADC_CLK === 1'b1);
        end
        tests++; if (bad !== 0)       begin fails++; $display("FAIL idle_outputs: %0d bad cycles required 0", bad); end
        tests++; if (first_rise != 2) begin fails++; $display("FAIL adc_clk_first_rise: cycle %0d required 2", first_rise); end
        tests++; if (bad_per != 0)    begin fails++; $display("FAIL adc_clk_period: %0d periods differ from 4", bad_per); end
        tests++; if (n_rise < 9)      begin fails++; $display("FAIL adc_clk_rises: got %0d required >= 9", n_rise); end
    endtask

    task automatic test_level_trigger();
        int         t;
        int         bad_gap;
        logic [1:0] last_state;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        for (int i = 0; i < DEPTH; i++) stim[i] = 8'(100 + 10 * i);
        stim_len = DEPTH;
        start_armed(0);
        last_state = STATE;
        for (int c = 0; c < 40; c++) begin
            if (hist.size() - arm_base >= 4) break;
            last_state = STATE;
            @(negedge CLK);
        end
        tests++; if (last_state !== ST_ARMED) begin fails++; $display("FAIL ramp_pre_trig_state: got %0d required 1", last_state); end
        tests++; if (STATE !== ST_CAPTURE)    begin fails++; $display("FAIL ramp_post_trig_state: got %0d required 2", STATE); end
        collect(0, 0, 400);
        t = find_trig(arm_base);
        tests++; if (t - arm_base != 3) begin fails++; $display("FAIL ramp_trig_index: got %0d required 3", t - arm_base); end
        tests++; if (got_q.size() != DEPTH) begin fails++; $display("FAIL ramp_count: got %0d required %0d", got_q.size(), DEPTH); end
        for (int k = 0; k < DEPTH; k++) begin
            exp_b = (t >= 0 && t + k < hist.size()) ? hist[t+k] : 8'hxx;
            got_b = (k < got_q.size()) ? got_q[k] : 8'hxx;
            tests++;
            if (got_b !== exp_b) begin fails++; $display("FAIL ramp_byte%0d: got %0d required %0d", k, got_b, exp_b); end
        end
        tests++; if (done_cnt != 1)         begin fails++; $display("FAIL ramp_done_count: got %0d required 1", done_cnt); end
        tests++; if (done_state !== ST_IDLE) begin fails++; $display("FAIL ramp_done_state: got %0d required 0", done_state); end
        tests++; if (first_vld - first_rd != 2) begin fails++; $display("FAIL ramp_first_valid_latency: got %0d required 2", first_vld - first_rd); end
        bad_gap = 0;
        for (int k = 1; k < hs_cyc.size(); k++) if (hs_cyc[k] - hs_cyc[k-1] != 2) bad_gap++;
        tests++; if (bad_gap != 0) begin fails++; $display("FAIL ramp_throughput: %0d gaps differ from 2 cycles", bad_gap); end
    endtask

    task automatic test_random_trigger();
        int         t;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++) stim[i] = 8'($urandom_range(0, 255));
            stim[12] = 8'd50;
            stim[13] = 8'd200;
            stim_len = 40;
            start_armed(0);
            collect(1, 0, 800);
            t = find_trig(arm_base);
            tests++; if (got_q.size() != DEPTH || t < 0) begin fails++; $display("FAIL rand%0d_count: got %0d bytes (trig %0d) required %0d", r, got_q.size(), t, DEPTH); end
            for (int k = 0; k < DEPTH; k++) begin
                exp_b = (t >= 0 && t + k < hist.size()) ? hist[t+k] : 8'hxx;
                got_b = (k < got_q.size()) ? got_q[k] : 8'hxx;
                tests++;
                if (got_b !== exp_b) begin fails++; $display("FAIL rand%0d_byte%0d: got %0d required %0d", r, k, got_b, exp_b); end
            end
            tests++; if (done_cnt != 1 || viol_cnt != 0) begin fails++; $display("FAIL rand%0d_protocol: done %0d viol %0d required 1 and 0", r, done_cnt, viol_cnt); end
        end
    endtask

    task automatic test_force_backpressure();
        int         fidx;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        for (int i = 0; i < 40; i++) stim[i] = 8'($urandom_range(128, 255));
        stim_len = 40;
        start_armed(1);
        tests++; if (STATE !== ST_ARMED) begin fails++; $display("FAIL arm_force_same_cycle: state %0d required 1", STATE); end
        repeat (6) wait_strobe();
        tests++; if (STATE !== ST_ARMED) begin fails++; $display("FAIL no_trig_above_level: state %0d required 1", STATE); end
        FORCE = 1'b1;
        fidx  = hist.size();
        @(negedge CLK);
        FORCE = 1'b0;
        tests++; if (STATE !== ST_CAPTURE) begin fails++; $display("FAIL force_state: got %0d required 2", STATE); end
        collect(2, 0, 600);
        tests++; if (got_q.size() != DEPTH) begin fails++; $display("FAIL force_count: got %0d required %0d", got_q.size(), DEPTH); end
        for (int k = 0; k < DEPTH; k++) begin
            exp_b = (fidx + k < hist.size()) ? hist[fidx+k] : 8'hxx;
            got_b = (k < got_q.size()) ? got_q[k] : 8'hxx;
            tests++;
            if (got_b !== exp_b) begin fails++; $display("FAIL force_byte%0d: got %0d required %0d", k, got_b, exp_b); end
        end
        tests++; if (viol_cnt != 0) begin fails++; $display("FAIL stall_stability: %0d violations required 0", viol_cnt); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL force_done_count: got %0d required 1", done_cnt); end
    endtask

    task automatic test_reset_mid_capture();
        int         fidx;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        stim[0]  = 8'd200;
        stim_len = 1;
        start_armed(0);
        wait_strobe();
        FORCE = 1'b1;
        @(negedge CLK);
        FORCE = 1'b0;
        repeat (4) wait_strobe();
        repeat (3) @(negedge CLK);
        tests++; if (STATE !== ST_CAPTURE) begin fails++; $display("FAIL pre_reset_state: got %0d required 2", STATE); end
        RST = 1'b1;
        @(negedge CLK);
        tests++;
        if (STATE !== ST_IDLE || BUSY !== 1'b0 || DONE !== 1'b0 || bus.OUT_VALID !== 1'b0
            || bus.OUT_DATA !== 8'd0 || ADC_CLK !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_outputs: state %0d busy %b done %b vld %b dat %0d adc_clk %b required all 0",
                     STATE, BUSY, DONE, bus.OUT_VALID, bus.OUT_DATA, ADC_CLK);
        end
        RST = 1'b0;
        for (int i = 0; i < 40; i++) stim[i] = 8'($urandom_range(128, 255));
        stim_len = 40;
        start_armed(0);
        wait_strobe();
        FORCE = 1'b1;
        fidx  = hist.size();
        @(negedge CLK);
        FORCE = 1'b0;
        collect(0, 0, 400);
        tests++; if (got_q.size() != DEPTH) begin fails++; $display("FAIL post_reset_count: got %0d required %0d", got_q.size(), DEPTH); end
        for (int k = 0; k < DEPTH; k++) begin
            exp_b = (fidx + k < hist.size()) ? hist[fidx+k] : 8'hxx;
            got_b = (k < got_q.size()) ? got_q[k] : 8'hxx;
            tests++;
            if (got_b !== exp_b) begin fails++; $display("FAIL post_reset_byte%0d: got %0d required %0d", k, got_b, exp_b); end
        end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL post_reset_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_ignored_requests();
        int         fidx;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        for (int i = 0; i < 40; i++) stim[i] = 8'($urandom_range(128, 255));
        stim_len = 40;
        start_armed(0);
        wait_strobe();
        FORCE = 1'b1;
        fidx  = hist.size();
        @(negedge CLK);
        FORCE = 1'b0;
        repeat (3) wait_strobe();
        ARM = 1'b1;
        @(negedge CLK);
        ARM = 1'b0;
        tests++; if (STATE !== ST_CAPTURE) begin fails++; $display("FAIL arm_in_capture: state %0d required 2", STATE); end
        collect(1, 1, 600);
        tests++; if (got_q.size() != DEPTH) begin fails++; $display("FAIL ignored_count: got %0d required %0d", got_q.size(), DEPTH); end
        for (int k = 0; k < DEPTH; k++) begin
            exp_b = (fidx + k < hist.size()) ? hist[fidx+k] : 8'hxx;
            got_b = (k < got_q.size()) ? got_q[k] : 8'hxx;
            tests++;
            if (got_b !== exp_b) begin fails++; $display("FAIL ignored_byte%0d: got %0d required %0d", k, got_b, exp_b); end
        end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL ignored_done_count: got %0d required 1", done_cnt); end
        tests++; if (STATE !== ST_IDLE || BUSY !== 1'b0) begin fails++; $display("FAIL ignored_final_state: state %0d busy %b required 0 0", STATE, BUSY); end
    endtask

    initial begin
        bus.OUT_READY = 1'b0;
        test_reset();
        test_level_trigger();
        test_random_trigger();
        test_force_backpressure();
        test_reset_mid_capture();
        test_ignored_requests();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 50000 cycles, required completion");
        $fatal(1);
    end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Single-shot capture sequencer for the 8-bit parallel ADC. Generates ADC_CLK and waits for an arm request followed by a level trigger or a forced trigger. It then records a fixed-length burst of samples into an internal buffer and streams the buffer out over a valid/ready byte interface, which normally feeds the UART transmitter on FTB1. STATE is exported for display on LED.

## Interface
Parameters:
- DIV, 2: ADC_CLK half-period in CLK cycles; legal range ≥1. Sample rate is CLK/(2·DIV).
- DEPTH_LOG2, 10: buffer depth is 2^DEPTH_LOG2 samples.
- TRIG_LEVEL, 8'd128: rising-edge trigger threshold, unsigned.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- ARM  in  1  single-cycle arm request; honoured only in IDLE
- FORCE  in  1  immediate trigger while ARMED
- ADC_D  in  8  ADC parallel data, unsigned
- ADC_CLK  out  1  ADC sample clock
- OUT_DATA  out  8  readout byte
- OUT_VALID  out  1  OUT_DATA valid
- OUT_READY  in  1  consumer accepts byte
- BUSY  out  1  high in any state other than IDLE
- DONE  out  1  one-cycle pulse when the last byte is accepted
- STATE  out  2  IDLE=0, ARMED=1, CAPTURE=2, READOUT=3

## Operation
- Divider: div_cnt runs 0..DIV-1. At wrap, ADC_CLK toggles. The divider runs free in every state, including IDLE.
- sample_stb: one-CLK pulse on the cycle ADC_CLK is registered 1→0. On that cycle ADC_D is registered as cur; the previous cur is kept as prev.
- Trigger condition, evaluated only on sample_stb: prev < TRIG_LEVEL and cur ≥ TRIG_LEVEL. prev is invalid on the first strobe after entering ARMED, so no level trigger is possible on that strobe.
- State machine:
  - IDLE: ARM=1 → ARMED.
  - ARMED: on a level trigger, or FORCE=1 on any cycle → CAPTURE. A level trigger writes its sample to address 0. FORCE writes on the next strobe.
  - CAPTURE: each sample_stb writes cur to wr_addr and increments it. After the write to address 2^DEPTH_LOG2−1, wr_addr wraps to 0 and the state moves to READOUT. No further writes occur.
  - READOUT: bytes are read from address 0 upward. A byte advances on OUT_VALID&&OUT_READY. When the last address is accepted, DONE pulses and the state moves to IDLE.
- ARM while not IDLE: ignored. FORCE outside ARMED: ignored.
- OUT_DATA holds steady while OUT_VALID=1 and OUT_READY=0. OUT_VALID never drops without a handshake.
- Arithmetic: wr_addr and rd_addr are DEPTH_LOG2 bits wide and wrap modulo the depth. The trigger compare is unsigned 8-bit.

## Timing
- Reset values: ADC_CLK=0, OUT_DATA=0, OUT_VALID=0, BUSY=0, DONE=0, STATE=0. Both address counters, div_cnt, prev and cur are also 0.
- RST mid-operation: next cycle is IDLE. Outputs take their reset values, the buffer contents are don't-care, and any in-flight byte is discarded with no DONE pulse.
- Buffer read latency is 1 cycle. OUT_VALID first asserts 2 cycles after entering READOUT.
- After each handshake, OUT_VALID is low for exactly 1 cycle, then high with the next byte. Maximum throughput is 1 byte per 2 cycles.
- DONE is asserted on the cycle after the final handshake, coincident with STATE=0.
- Level trigger to first write: the trigger sample is written on the same cycle that sample_stb is seen; STATE=2 on the following cycle.
- ARM and FORCE asserted on the same cycle in IDLE: only ARM is honoured.

## Structure
- Shared package adc_pkg holds the state encoding constants (ST_IDLE, ST_ARMED, ST_CAPTURE, ST_READOUT) and the default TRIG_LEVEL.
- Sub-module adc_sample_ram: simple dual-port, 2^DEPTH_LOG2×8, one write port and one read port with 1-cycle registered read. It infers block RAM.
- The divider, trigger detection, FSM and readout handshake stay in adc_capture_ctrl.

## Test plan
All scenarios use DIV=2 and DEPTH_LOG2=4.
- Reset, then run 40 cycles → ADC_CLK period is 4 CLK; BUSY=0, STATE=0, OUT_VALID=0 throughout.
- ARM, then ADC_D ramps 100,110,…,250 per strobe → trigger at sample 130. OUT bytes are 130,140,…,250,250,250,250 (16 bytes, the stream saturates at 250). DONE pulses once and STATE returns to 0.
- ARM with ADC_D held at 200 → no trigger; stays in STATE=1. Then FORCE=1 → 16 bytes of 200 are read out.
- During READOUT, hold OUT_READY=0 for 10 cycles → OUT_DATA and OUT_VALID stay stable. Release → the sequence resumes with no loss or duplicate.
- Assert RST at the 5th CAPTURE write → next cycle STATE=0 and all outputs 0. A new ARM/FORCE capture then completes normally with 16 bytes.
- ARM pulsed during CAPTURE and FORCE pulsed during READOUT → both ignored. Exactly 16 bytes and one DONE result.
